// File: rtl/mem_port_arbiter_if.sv
// Bundle of every handshake/bus signal around mem_port_arbiter.
//   if_*  : instruction-fetch read port (core side)
//   dm_*  : data-memory read/write port (core side)
//   mem_* : single downstream memory port (RAM/bus side)
// Modports:
//   slave  - the arbiter: takes core requests, drives the memory port
//   master - the environment (core + memory): issues requests, answers reads
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic              if_req_valid_in;
    logic [AW-1:0]     if_addr_in;
    logic              if_req_ready_out;
    logic              if_resp_valid_out;
    logic [DW-1:0]     if_rdata_out;

    logic              dm_req_valid_in;
    logic              dm_we_in;
    logic [AW-1:0]     dm_addr_in;
    logic [DW-1:0]     dm_wdata_in;
    logic [DW/8-1:0]   dm_byte_en_in;
    logic              dm_req_ready_out;
    logic              dm_resp_valid_out;
    logic [DW-1:0]     dm_rdata_out;

    logic              mem_valid_out;
    logic              mem_ready_in;
    logic              mem_read_en_out;
    logic              mem_write_en_out;
    logic [AW-1:0]     mem_addr_out;
    logic [DW-1:0]     mem_wdata_out;
    logic [DW/8-1:0]   mem_byte_en_out;
    logic              mem_rvalid_in;
    logic [DW-1:0]     mem_rdata_in;

    logic              err_out;
    logic              busy_out;

    modport slave (
        input  if_req_valid_in, if_addr_in,
        output if_req_ready_out, if_resp_valid_out, if_rdata_out,
        input  dm_req_valid_in, dm_we_in, dm_addr_in, dm_wdata_in, dm_byte_en_in,
        output dm_req_ready_out, dm_resp_valid_out, dm_rdata_out,
        output mem_valid_out, mem_read_en_out, mem_write_en_out, mem_addr_out,
        output mem_wdata_out, mem_byte_en_out,
        input  mem_ready_in, mem_rvalid_in, mem_rdata_in,
        output err_out, busy_out
    );

    modport master (
        output if_req_valid_in, if_addr_in,
        input  if_req_ready_out, if_resp_valid_out, if_rdata_out,
        output dm_req_valid_in, dm_we_in, dm_addr_in, dm_wdata_in, dm_byte_en_in,
        input  dm_req_ready_out, dm_resp_valid_out, dm_rdata_out,
        input  mem_valid_out, mem_read_en_out, mem_write_en_out, mem_addr_out,
        input  mem_wdata_out, mem_byte_en_out,
        output mem_ready_in, mem_rvalid_in, mem_rdata_in,
        input  err_out, busy_out
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the instruction-fetch (IF)
// and data-memory (DM) requesters, one transaction at a time:
// arbitrate -> issue downstream -> wait for response -> return to owner.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - mem_port_arbiter_if.slave (IF/DM request ports, memory port,
//          err_out timeout pulse, busy_out)
// Parameters:
//   AW, DW   - address / data width (byte enables are DW/8)
//   TIMEOUT  - cycles allowed in REQ or RESP before abort; 0 disables abort
// Build option:
//   ARB_ROUND_ROBIN_EN - when defined, simultaneous requests alternate with the
//                        last-granted owner losing the tie; otherwise DM always
//                        wins a tie.
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned BW = DW / 8;
    // Last counter value before abort; only meaningful when TIMEOUT != 0.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;
    typedef enum logic {OwnIf = 1'b0, OwnDm = 1'b1} owner_e;

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [BW-1:0] be_q, be_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          err_q, err_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          mem_valid_q, mem_rd_q, mem_wr_q;
    // Low while reset is applied and for the first cycle after release, so the
    // combinational ready pulses stay at 0 during reset.
    logic          en_q;
    logic          grant_if, grant_dm;
    logic          expired;

`ifdef ARB_ROUND_ROBIN_EN
    owner_e last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= OwnIf;
        end else if (grant_if) begin
            last_q <= OwnIf;
        end else if (grant_dm) begin
            last_q <= OwnDm;
        end
    end
`endif

    // Arbitration: only in IDLE, so nothing is accepted while busy.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (en_q && state_q == StIdle) begin
            if (bus.dm_req_valid_in && bus.if_req_valid_in) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (last_q == OwnDm) begin
                    grant_if = 1'b1;
                end else begin
                    grant_dm = 1'b1;
                end
`else
                grant_dm = 1'b1;
`endif
            end else begin
                grant_if = bus.if_req_valid_in;
                grant_dm = bus.dm_req_valid_in;
            end
        end
    end

    assign expired = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        err_d      = err_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            StIdle: begin
                err_d = 1'b0;
                cnt_d = '0;
                if (grant_dm) begin
                    owner_d = OwnDm;
                    we_d    = bus.dm_we_in;
                    addr_d  = bus.dm_addr_in;
                    wdata_d = bus.dm_wdata_in;
                    be_d    = bus.dm_byte_en_in;
                    state_d = StReq;
                end else if (grant_if) begin
                    owner_d = OwnIf;
                    we_d    = 1'b0;
                    addr_d  = bus.if_addr_in;
                    wdata_d = '0;
                    be_d    = '1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (bus.mem_ready_in) begin
                    state_d = we_q ? StDone : StResp;
                    cnt_d   = '0;
                end else if (expired) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                    if (owner_q == OwnIf) begin
                        if_rdata_d = '0;
                    end else begin
                        dm_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StResp: begin
                // Data arriving on the expiry cycle takes precedence.
                if (bus.mem_rvalid_in) begin
                    state_d = StDone;
                    if (owner_q == OwnIf) begin
                        if_rdata_d = bus.mem_rdata_in;
                    end else begin
                        dm_rdata_d = bus.mem_rdata_in;
                    end
                end else if (expired) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                    if (owner_q == OwnIf) begin
                        if_rdata_d = '0;
                    end else begin
                        dm_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
                err_d   = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            owner_q     <= OwnIf;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            // Registered strobes track the next state, so they are high exactly
            // while the FSM sits in REQ.
            mem_valid_q <= (state_d == StReq);
            mem_rd_q    <= (state_d == StReq) && !we_d;
            mem_wr_q    <= (state_d == StReq) && we_d;
            en_q        <= 1'b1;
        end
    end

    assign bus.if_req_ready_out  = grant_if;
    assign bus.dm_req_ready_out  = grant_dm;
    assign bus.if_resp_valid_out = (state_q == StDone) && (owner_q == OwnIf);
    assign bus.dm_resp_valid_out = (state_q == StDone) && (owner_q == OwnDm);
    assign bus.if_rdata_out      = if_rdata_q;
    assign bus.dm_rdata_out      = dm_rdata_q;
    assign bus.mem_valid_out     = mem_valid_q;
    assign bus.mem_read_en_out   = mem_rd_q;
    assign bus.mem_write_en_out  = mem_wr_q;
    assign bus.mem_addr_out      = addr_q;
    assign bus.mem_wdata_out     = wdata_q;
    assign bus.mem_byte_en_out   = be_q;
    assign bus.err_out           = err_q;
    assign bus.busy_out          = (state_q != StIdle);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT = 8).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, got busy=%0b required finish", bus.busy_out);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // IF read with zero-wait memory; checks the cycle-exact handshake.
    task automatic if_read_check(input logic [31:0] a, input logic [31:0] d);
        bus.if_req_valid_in = 1'b1; bus.if_addr_in = a;
        bus.mem_ready_in = 1'b1; bus.mem_rvalid_in = 1'b0;
        @(negedge clk); // cycle 1
        total++; if (bus.if_req_ready_out !== 1'b1) begin bad++; $display("FAIL rd_c1_ready got=%b want=1", bus.if_req_ready_out); end
        total++; if (bus.mem_valid_out !== 1'b0) begin bad++; $display("FAIL rd_c1_memvalid got=%b want=0", bus.mem_valid_out); end
        tick(); bus.if_req_valid_in = 1'b0; bus.if_addr_in = 32'hFFFF_FFFF;
        @(negedge clk); // cycle 2
        total++; if (bus.mem_valid_out !== 1'b1) begin bad++; $display("FAIL rd_c2_memvalid got=%b want=1", bus.mem_valid_out); end
        total++; if (bus.mem_read_en_out !== 1'b1 || bus.mem_write_en_out !== 1'b0) begin bad++; $display("FAIL rd_c2_rdwr got=%b%b want=10", bus.mem_read_en_out, bus.mem_write_en_out); end
        total++; if (bus.mem_addr_out !== a) begin bad++; $display("FAIL rd_c2_addr got=%h want=%h", bus.mem_addr_out, a); end
        total++; if (bus.mem_byte_en_out !== 4'hF || bus.mem_wdata_out !== 32'h0) begin bad++; $display("FAIL rd_c2_be_wdata got=%h/%h want=f/0", bus.mem_byte_en_out, bus.mem_wdata_out); end
        tick(); bus.mem_rvalid_in = 1'b1; bus.mem_rdata_in = d;
        @(negedge clk); // cycle 3
        total++; if (bus.if_resp_valid_out !== 1'b0 || bus.mem_valid_out !== 1'b0) begin bad++; $display("FAIL rd_c3 got resp=%b memvalid=%b want 0/0", bus.if_resp_valid_out, bus.mem_valid_out); end
        tick(); bus.mem_rvalid_in = 1'b0; bus.mem_rdata_in = 32'h0;
        @(negedge clk); // cycle 4
        total++; if (bus.if_resp_valid_out !== 1'b1) begin bad++; $display("FAIL rd_c4_resp got=%b want=1", bus.if_resp_valid_out); end
        total++; if (bus.if_rdata_out !== d) begin bad++; $display("FAIL rd_c4_rdata got=%h want=%h", bus.if_rdata_out, d); end
        total++; if (bus.dm_resp_valid_out !== 1'b0 || bus.err_out !== 1'b0) begin bad++; $display("FAIL rd_c4_other got dm=%b err=%b want 0/0", bus.dm_resp_valid_out, bus.err_out); end
        tick();
        @(negedge clk); // cycle 5
        total++; if (bus.if_resp_valid_out !== 1'b0 || bus.busy_out !== 1'b0) begin bad++; $display("FAIL rd_c5 got resp=%b busy=%b want 0/0", bus.if_resp_valid_out, bus.busy_out); end
        total++; if (bus.if_rdata_out !== d) begin bad++; $display("FAIL rd_c5_hold got=%h want=%h", bus.if_rdata_out, d); end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.if_req_valid_in = 1'b1; bus.if_addr_in = 32'h0;
        bus.dm_req_valid_in = 1'b1; bus.dm_we_in = 1'b0; bus.dm_addr_in = 32'h0;
        bus.dm_wdata_in = 32'h0; bus.dm_byte_en_in = 4'h0;
        bus.mem_ready_in = 1'b0; bus.mem_rvalid_in = 1'b0; bus.mem_rdata_in = 32'h0;
        repeat (2) @(negedge clk);
        total++; if (bus.if_req_ready_out !== 1'b0 || bus.dm_req_ready_out !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b%b want=00", bus.if_req_ready_out, bus.dm_req_ready_out); end
        total++; if (bus.busy_out !== 1'b0 || bus.mem_valid_out !== 1'b0 || bus.err_out !== 1'b0) begin bad++; $display("FAIL rst_ctrl got busy=%b mv=%b err=%b want 0", bus.busy_out, bus.mem_valid_out, bus.err_out); end
        total++; if (bus.if_rdata_out !== 32'h0 || bus.dm_rdata_out !== 32'h0 || bus.mem_addr_out !== 32'h0) begin bad++; $display("FAIL rst_data got %h %h %h want 0", bus.if_rdata_out, bus.dm_rdata_out, bus.mem_addr_out); end
        tick();
        bus.if_req_valid_in = 1'b0; bus.dm_req_valid_in = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_if_read();
        if_read_check(32'h0000_0100, 32'hDEAD_BEEF);
    endtask

    task automatic test_arbitration();
        logic exp_dm [4];
        logic got_dm [4];
        int   n;
        int   cyc;
`ifdef ARB_ROUND_ROBIN_EN
        exp_dm[0] = 1'b1; exp_dm[1] = 1'b0; exp_dm[2] = 1'b1; exp_dm[3] = 1'b0;
`else
        exp_dm[0] = 1'b1; exp_dm[1] = 1'b1; exp_dm[2] = 1'b1; exp_dm[3] = 1'b1;
`endif
        n = 0; cyc = 0;
        bus.dm_req_valid_in = 1'b1; bus.dm_we_in = 1'b0; bus.dm_addr_in = 32'h40;
        bus.if_req_valid_in = 1'b1; bus.if_addr_in = 32'h80;
        bus.mem_ready_in = 1'b1; bus.mem_rvalid_in = 1'b1; bus.mem_rdata_in = 32'hA5A5_0000;
        while (n < 4 && cyc < 40) begin
            @(negedge clk);
            if (bus.dm_req_ready_out === 1'b1 && bus.if_req_ready_out === 1'b1) begin
                total++; bad++; $display("FAIL arb_both_ready got=11 want one-hot");
            end
            if (bus.dm_req_ready_out === 1'b1) begin got_dm[n] = 1'b1; n++; end
            else if (bus.if_req_ready_out === 1'b1) begin got_dm[n] = 1'b0; n++; end
            tick();
            cyc++;
        end
        bus.dm_req_valid_in = 1'b0; bus.if_req_valid_in = 1'b0;
        total++; if (n != 4) begin bad++; $display("FAIL arb_grants got=%0d want=4", n); end
        for (int i = 0; i < n; i++) begin
            total++;
            if (got_dm[i] !== exp_dm[i]) begin bad++; $display("FAIL arb_grant%0d got_dm=%b want_dm=%b", i, got_dm[i], exp_dm[i]); end
        end
        cyc = 0;
        while (bus.busy_out !== 1'b0 && cyc < 10) begin tick(); cyc++; end
        total++; if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL arb_idle got busy=%b want=0", bus.busy_out); end
        bus.mem_rvalid_in = 1'b0; bus.mem_rdata_in = 32'h0; bus.mem_ready_in = 1'b0;
        tick();
    endtask

    task automatic test_dm_write();
        int resp_cnt;
        logic rd_seen;
        resp_cnt = 0; rd_seen = 1'b0;
        bus.dm_req_valid_in = 1'b1; bus.dm_we_in = 1'b1; bus.dm_addr_in = 32'h2000;
        bus.dm_wdata_in = 32'h1234_5678; bus.dm_byte_en_in = 4'b0011;
        bus.mem_ready_in = 1'b0; bus.mem_rvalid_in = 1'b0;
        @(negedge clk); // cycle 1
        total++; if (bus.dm_req_ready_out !== 1'b1) begin bad++; $display("FAIL wr_ready got=%b want=1", bus.dm_req_ready_out); end
        for (int c = 2; c <= 5; c++) begin
            tick();
            if (c == 2) begin
                bus.dm_req_valid_in = 1'b0; bus.dm_we_in = 1'b0; bus.dm_addr_in = 32'hFFFF_FFFF;
                bus.dm_wdata_in = 32'h0; bus.dm_byte_en_in = 4'hC;
            end
            bus.mem_ready_in = (c == 5);
            @(negedge clk);
            if (bus.mem_read_en_out === 1'b1) rd_seen = 1'b1;
            total++; if (bus.mem_valid_out !== 1'b1 || bus.mem_write_en_out !== 1'b1) begin bad++; $display("FAIL wr_c%0d_strobe got mv=%b we=%b want 1/1", c, bus.mem_valid_out, bus.mem_write_en_out); end
            total++; if (bus.mem_addr_out !== 32'h2000 || bus.mem_wdata_out !== 32'h1234_5678 || bus.mem_byte_en_out !== 4'b0011) begin bad++; $display("FAIL wr_c%0d_fields got %h %h %b want 2000 12345678 0011", c, bus.mem_addr_out, bus.mem_wdata_out, bus.mem_byte_en_out); end
            if (bus.dm_resp_valid_out === 1'b1) resp_cnt++;
        end
        tick(); bus.mem_ready_in = 1'b0;
        @(negedge clk); // cycle 6
        if (bus.mem_read_en_out === 1'b1) rd_seen = 1'b1;
        total++; if (bus.dm_resp_valid_out !== 1'b1 || bus.mem_valid_out !== 1'b0) begin bad++; $display("FAIL wr_c6 got resp=%b mv=%b want 1/0", bus.dm_resp_valid_out, bus.mem_valid_out); end
        if (bus.dm_resp_valid_out === 1'b1) resp_cnt++;
        tick();
        @(negedge clk); // cycle 7
        if (bus.dm_resp_valid_out === 1'b1) resp_cnt++;
        total++; if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL wr_c7_busy got=%b want=0", bus.busy_out); end
        total++; if (resp_cnt != 1) begin bad++; $display("FAIL wr_resp_count got=%0d want=1", resp_cnt); end
        total++; if (rd_seen !== 1'b0) begin bad++; $display("FAIL wr_read_en got=%b want=0", rd_seen); end
        tick();
    endtask

    // Race 0: memory silent -> abort in cycle 11. Race 1: data on expiry cycle.
    task automatic test_timeout();
        int k;
        logic got;
        for (int race = 0; race < 2; race++) begin
            bus.dm_req_valid_in = 1'b1; bus.dm_we_in = 1'b0; bus.dm_addr_in = 32'h3000;
            bus.mem_ready_in = 1'b1; bus.mem_rvalid_in = 1'b0; bus.mem_rdata_in = 32'h5555_5555;
            @(negedge clk); // cycle 1
            total++; if (bus.dm_req_ready_out !== 1'b1) begin bad++; $display("FAIL to%0d_ready got=%b want=1", race, bus.dm_req_ready_out); end
            k = 1; got = 1'b0;
            while (k < 30 && !got) begin
                tick();
                k++;
                if (k == 2) bus.dm_req_valid_in = 1'b0;
                bus.mem_rvalid_in = (race == 1) && (k == 10);
                @(negedge clk);
                if (bus.dm_resp_valid_out === 1'b1) got = 1'b1;
            end
            bus.mem_rvalid_in = 1'b0;
            total++; if (!got || k != 11) begin bad++; $display("FAIL to%0d_cycle got=%0d want=11", race, k); end
            total++; if (bus.err_out !== (race == 0)) begin bad++; $display("FAIL to%0d_err got=%b want=%b", race, bus.err_out, race == 0); end
            total++; if (bus.dm_rdata_out !== ((race == 0) ? 32'h0 : 32'h5555_5555)) begin bad++; $display("FAIL to%0d_rdata got=%h", race, bus.dm_rdata_out); end
            tick();
            @(negedge clk);
            total++; if (bus.busy_out !== 1'b0 || bus.err_out !== 1'b0) begin bad++; $display("FAIL to%0d_idle got busy=%b err=%b want 0/0", race, bus.busy_out, bus.err_out); end
            tick();
        end
        bus.mem_ready_in = 1'b0;
    endtask

    task automatic test_reset_in_resp();
        bus.if_req_valid_in = 1'b1; bus.if_addr_in = 32'h400;
        bus.mem_ready_in = 1'b1; bus.mem_rvalid_in = 1'b0;
        @(negedge clk);
        tick(); bus.if_req_valid_in = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk); // RESP, memory silent
        total++; if (bus.busy_out !== 1'b1 || bus.mem_addr_out !== 32'h400) begin bad++; $display("FAIL rr_pre got busy=%b addr=%h want 1/400", bus.busy_out, bus.mem_addr_out); end
        #1 rst = 1'b0;
        #1;
        total++; if (bus.busy_out !== 1'b0 || bus.mem_valid_out !== 1'b0 || bus.mem_read_en_out !== 1'b0) begin bad++; $display("FAIL rr_ctrl got busy=%b mv=%b rd=%b want 0", bus.busy_out, bus.mem_valid_out, bus.mem_read_en_out); end
        total++; if (bus.if_resp_valid_out !== 1'b0 || bus.dm_resp_valid_out !== 1'b0 || bus.err_out !== 1'b0) begin bad++; $display("FAIL rr_resp got %b%b%b want 000", bus.if_resp_valid_out, bus.dm_resp_valid_out, bus.err_out); end
        total++; if (bus.mem_addr_out !== 32'h0 || bus.if_rdata_out !== 32'h0 || bus.mem_byte_en_out !== 4'h0) begin bad++; $display("FAIL rr_data got %h %h %h want 0", bus.mem_addr_out, bus.if_rdata_out, bus.mem_byte_en_out); end
        tick();
        tick(); rst = 1'b1;
        tick();
        if_read_check(32'h300, 32'hCAFE_F00D);
    endtask

    task automatic test_spurious_rvalid();
        bus.mem_ready_in = 1'b0; bus.mem_rvalid_in = 1'b1; bus.mem_rdata_in = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (bus.if_resp_valid_out !== 1'b0 || bus.dm_resp_valid_out !== 1'b0 || bus.busy_out !== 1'b0) begin bad++; $display("FAIL sp%0d_resp got %b%b busy=%b want 00/0", c, bus.if_resp_valid_out, bus.dm_resp_valid_out, bus.busy_out); end
            total++; if (bus.if_rdata_out !== 32'hCAFE_F00D || bus.dm_rdata_out !== 32'h0) begin bad++; $display("FAIL sp%0d_rdata got %h/%h want cafef00d/0", c, bus.if_rdata_out, bus.dm_rdata_out); end
            tick();
        end
        bus.mem_rvalid_in = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_if_read();
        test_arbitration();
        test_dm_write();
        test_timeout();
        test_reset_in_resp();
        test_spurious_rvalid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
